// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter among NUM_REQ byte producers.
//               Round-robin arbitration with a message lock, so a multi-byte
//               message is never interleaved with another requester's bytes.
//               Drives the UART trigger handshake and flags a sticky error
//               when the transmitter fails to start within START_TIMEOUT.
// Ports       : clk_i, rst_i              clock, async active-high reset
//               req_valid_i/data_i/last_i requester byte offers
//               req_ready_o               one-hot accept pulse
//               tx_data_o, tx_trigger_o   to UART tx_data_i / tx_trigger_i
//               tx_complete_i             from UART tx_complete_o (1 = idle)
//               grant_o, busy_o, err_o    status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]          req_last_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [DATA_W-1:0]           tx_data_o,
  output logic                        tx_trigger_o,
  input  logic                        tx_complete_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TRIG       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;   // last winner, also the lock owner
  logic                 lock_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic [DATA_W-1:0]    tx_data_q;
  logic                 tx_trigger_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 busy_q;
  logic                 err_q;

  // Arbitration result for the current cycle
  logic                 arb_found;
  logic [IDX_W-1:0]     arb_idx;
  logic [DATA_W-1:0]    arb_data;
  logic [IDX_W:0]       cand;

  // A held lock wins outright while its owner still offers a byte; otherwise
  // the lock is ignored here and released at the win below.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    if (lock_q && req_valid_i[rr_ptr_q]) begin
      arb_found = 1'b1;
      arb_idx   = rr_ptr_q;
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
        if (cand >= (IDX_W+1)'(NUM_REQ)) begin
          cand = cand - (IDX_W+1)'(NUM_REQ);
        end
        if (!arb_found && req_valid_i[cand[IDX_W-1:0]]) begin
          arb_found = 1'b1;
          arb_idx   = cand[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    arb_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        arb_data = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IDX_W'(NUM_REQ-1);
      lock_q       <= 1'b0;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      tx_data_q    <= '0;
      tx_trigger_q <= 1'b0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Accept and trigger are single-cycle pulses
      req_ready_q  <= '0;
      tx_trigger_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_complete_i && arb_found) begin
            state_q      <= TRIG;
            rr_ptr_q     <= arb_idx;
            lock_q       <= ~req_last_i[arb_idx];
            req_ready_q  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
            grant_q      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
            tx_data_q    <= arb_data;
            tx_trigger_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        TRIG: begin
          state_q <= WAIT_START;
          cnt_q   <= '0;
        end
        WAIT_START: begin
          if (!tx_complete_i) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CNT_W'(START_TIMEOUT-1)) begin
            // UART never acknowledged: give up, drop any message lock
            err_q   <= 1'b1;
            lock_q  <= 1'b0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_complete_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign tx_data_o    = tx_data_q;
  assign tx_trigger_o = tx_trigger_q;
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte producers (e.g. loopback echo, status reporter, debug dumper).
- Arbitrates round-robin, with an optional message lock so multi-byte messages are never interleaved.
- Drives the UART TX handshake (data, one-cycle trigger, complete/ready) and supervises it with a start timeout.
- Sits between the requesters and the uart block's tx_data_i / tx_trigger_i / tx_complete_o pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, bits per UART byte.
- START_TIMEOUT, 16, cycles to wait for tx_complete_i to fall after a trigger before declaring an error.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  NUM_REQ  requester n has a byte; held high with stable data until accepted.
- req_data_i  in  NUM_REQ*DATA_W  byte of requester n, at bits [n*DATA_W +: DATA_W].
- req_last_i  in  NUM_REQ  byte of requester n is the last byte of its message.
- req_ready_o  out  NUM_REQ  one-cycle accept pulse, one-hot.
- tx_data_o  out  DATA_W  to uart tx_data_i.
- tx_trigger_o  out  1  to uart tx_trigger_i; one-cycle pulse.
- tx_complete_i  in  1  from uart tx_complete_o; high = transmitter idle.
- grant_o  out  NUM_REQ  one-hot current/last owner.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  sticky start-timeout flag; cleared only by reset.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, state IDLE, rr_ptr = NUM_REQ-1 (requester 0 has first priority), lock = 0, timeout counter = 0.
- All outputs are registered.
- FSM states: IDLE, TRIG, WAIT_START, WAIT_DONE.
- IDLE, arbitration:
  - Arbitrate only when tx_complete_i = 1 and at least one req_valid_i is high; otherwise stay in IDLE.
  - If lock = 1 and the locked owner's valid is high, the owner wins.
  - If lock = 1 and the owner's valid is low, clear lock and arbitrate normally in the same cycle.
  - Normal arbitration: search from rr_ptr+1 upward, wrapping modulo NUM_REQ. The first valid requester wins.
  - Win at cycle N: in cycle N+1, tx_data_o = winner's data, req_ready_o[winner] = 1, tx_trigger_o = 1, grant_o = winner one-hot, busy_o = 1, state TRIG.
  - Also at the win: rr_ptr = winner; lock = ~req_last_i[winner].
- TRIG (1 cycle): req_ready_o and tx_trigger_o return to 0 next cycle. Go to WAIT_START with counter = 0.
- WAIT_START:
  - tx_complete_i = 0 → WAIT_DONE.
  - Otherwise increment counter. When counter = START_TIMEOUT-1 and tx_complete_i is still 1: set err_o = 1, clear lock, go to IDLE.
- WAIT_DONE: tx_complete_i = 1 → IDLE. Earliest re-arbitration is the following cycle.
- tx_data_o holds its value until the next grant. grant_o holds the last owner in IDLE.
- Requesters never see a second ready while the arbiter is busy. A requester keeping valid high after its pulse is serviced only on a later arbitration.
- Valid deasserted before acceptance is legal (request withdrawn); no byte is lost or duplicated.
- Simultaneous events:
  - A new valid arriving in WAIT_DONE is not arbitrated until IDLE.
  - A lock owner with last = 1 on its final byte releases the lock at that grant.
- Reset mid-transfer aborts the sequence. The UART may finish its in-flight byte; the arbiter restarts in IDLE.

Test Plan:
- Single requester:
  - Stimulus: req1 valid, data 0x41, last 1; UART model drops complete 2 cycles after trigger and raises it 20 cycles later.
  - Response: one ready[1] pulse and one trigger pulse in the same cycle, tx_data_o = 0x41, busy_o low again the cycle after complete returns.
- Round-robin:
  - Stimulus: req0, req1, req2 all valid with 0x10/0x11/0x12, last 1, held continuously.
  - Response: transmit order 0x10, 0x11, 0x12, 0x10, …; req3 idle never granted.
- Lock:
  - Stimulus: req2 sends 3 bytes 0xA0, 0xA1, 0xA2 with last only on 0xA2, while req0 is continuously valid.
  - Response: order 0xA0, 0xA1, 0xA2, then req0's byte.
- Timeout:
  - Stimulus: UART model holds complete high after a trigger, START_TIMEOUT = 16.
  - Response: err_o rises after 16 WAIT_START cycles, state returns to IDLE, the next request is still serviced, err_o stays 1.
- Busy UART at start:
  - Stimulus: complete low while req0 is valid.
  - Response: no ready pulse and no trigger until complete goes high, then a grant one cycle later.
- Reset mid-WAIT_DONE:
  - Stimulus: assert rst_i asynchronously.
  - Response: all outputs 0 immediately. After release with req3 and req0 valid, req0 wins first (rr_ptr = NUM_REQ-1).
